// File: rtl/fir_controller_pkg.sv
// Shared types and constants for the 4-tap FIR sequencing controller:
// datapath op codes, register-file indices and FSM state encodings.
package fir_controller_pkg;

  localparam int OP_W      = 3;
  localparam int REG_SEL_W = 4;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_COPY  = 3'd1,
    OP_LOAD1 = 3'd2,   // load external sample
    OP_LOAD2 = 3'd3,   // load external coefficient
    OP_ADD   = 3'd4,
    OP_SUB   = 3'd5,
    OP_MUL   = 3'd6
  } op_t;

  // Register-file map: R0 accumulator/output, R1-R4 tap line (R1 newest),
  // R5-R8 coefficients F0-F3, R9 product scratch, R10 sample staging.
  localparam logic [3:0] R0  = 4'd0;
  localparam logic [3:0] R1  = 4'd1;
  localparam logic [3:0] R2  = 4'd2;
  localparam logic [3:0] R3  = 4'd3;
  localparam logic [3:0] R4  = 4'd4;
  localparam logic [3:0] R5  = 4'd5;
  localparam logic [3:0] R6  = 4'd6;
  localparam logic [3:0] R7  = 4'd7;
  localparam logic [3:0] R8  = 4'd8;
  localparam logic [3:0] R9  = 4'd9;
  localparam logic [3:0] R10 = 4'd10;

  // State encodings kept as plain constants so netlists and older
  // tooling see a fixed binary code for every state.
  typedef logic [4:0] state_t;

  localparam state_t S_IDLE  = 5'd0;
  localparam state_t S_STORE = 5'd1;
  localparam state_t S_ZERO  = 5'd2;
  localparam state_t S_SORT1 = 5'd3;
  localparam state_t S_SORT2 = 5'd4;
  localparam state_t S_SORT3 = 5'd5;
  localparam state_t S_SORT4 = 5'd6;
  localparam state_t S_MUL1  = 5'd7;
  localparam state_t S_ADD1  = 5'd8;
  localparam state_t S_MUL2  = 5'd9;
  localparam state_t S_SUB2  = 5'd10;
  localparam state_t S_MUL3  = 5'd11;
  localparam state_t S_ADD3  = 5'd12;
  localparam state_t S_MUL4  = 5'd13;
  localparam state_t S_SUB4  = 5'd14;
  localparam state_t S_LDC0  = 5'd15;
  localparam state_t S_LDC1  = 5'd16;
  localparam state_t S_LDC2  = 5'd17;
  localparam state_t S_LDC3  = 5'd18;
  localparam state_t S_WC0   = 5'd19;
  localparam state_t S_WC1   = 5'd20;
  localparam state_t S_WC2   = 5'd21;
  localparam state_t S_EIDLE = 5'd22;

  // States in which the controller is not busy: waiting for a sample,
  // waiting for the next coefficient, or parked after an error.
  function automatic logic is_wait_state(state_t s);
    return (s == S_IDLE) || (s == S_EIDLE) ||
           (s == S_WC0)  || (s == S_WC1)   || (s == S_WC2);
  endfunction

endpackage

// File: rtl/fir_controller_if.sv
// Control bundle between the FIR controller, the synchronizers feeding it
// and the register-file datapath it steers.
interface fir_controller_if #(
  parameter int OP_W      = 3,
  parameter int REG_SEL_W = 4
);

  logic                 dr;
  logic                 lc;
  logic                 overflow;
  logic                 cnt_up;
  logic                 clear;
  logic                 modwait;
  logic [OP_W-1:0]      op;
  logic [REG_SEL_W-1:0] src1;
  logic [REG_SEL_W-1:0] src2;
  logic [REG_SEL_W-1:0] dest;
  logic                 err;

  // Environment side: synchronized strobes in, datapath commands observed.
  modport master (
    output dr, lc, overflow,
    input  cnt_up, clear, modwait, op, src1, src2, dest, err
  );

  // Controller side.
  modport slave (
    input  dr, lc, overflow,
    output cnt_up, clear, modwait, op, src1, src2, dest, err
  );

endinterface

// File: rtl/fir_controller.sv
// Moore FSM sequencing a 4-tap FIR on a 16-entry register-file datapath.
// Loads four coefficients on load-coeff strobes; for each sample it stages
// the sample, shifts the tap line and runs a 4-step multiply/accumulate
// into R0. The controller never looks at data values; the datapath only
// reports ALU overflow on the accumulate steps.
//
//  state | meaning
//  ------+----------------------------------------------------------
//  IDLE  | waiting; dr starts a sample (priority), lc starts coeff load
//  STORE | LOAD1 sample into R10, pulse cnt_up; dr must still be high
//  ZERO  | R0 = R0 - R0
//  SORT1 | R4 <- R3
//  SORT2 | R3 <- R2
//  SORT3 | R2 <- R1
//  SORT4 | R1 <- R10
//  MUL1  | R9 = R1 * R5
//  ADD1  | R0 = R0 + R9   (overflow -> EIDLE)
//  MUL2  | R9 = R2 * R6
//  SUB2  | R0 = R0 - R9   (overflow -> EIDLE)
//  MUL3  | R9 = R3 * R7
//  ADD3  | R0 = R0 + R9   (overflow -> EIDLE)
//  MUL4  | R9 = R4 * R8
//  SUB4  | R0 = R0 - R9   (overflow -> EIDLE), else back to IDLE
//  LDCn  | LOAD2 coefficient n into R5+n; LDC0 also pulses clear
//  WCn   | wait for next lc strobe, no timeout, dr ignored
//  EIDLE | error park; err high; dr or lc restarts like IDLE
module fir_controller
  import fir_controller_pkg::*;
#(
  parameter int OP_W      = fir_controller_pkg::OP_W,
  parameter int REG_SEL_W = fir_controller_pkg::REG_SEL_W
) (
  input  logic                 clk,
  input  logic                 rst,
  fir_controller_if.slave      bus
);

  state_t               state;
  state_t               state_next;
  logic                 modwait_q;
  logic                 err_q;

  op_t                  op_c;
  logic [3:0]           src1_c;
  logic [3:0]           src2_c;
  logic [3:0]           dest_c;
  logic                 cnt_up_c;
  logic                 clear_c;

  // State register plus the two registered status flags, which are
  // computed from the next state so they line up with state entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      modwait_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_next;
      modwait_q <= !is_wait_state(state_next);
      err_q     <= (state_next == S_EIDLE);
    end
  end

  // Next-state logic; overflow is only honoured on accumulate steps.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (bus.dr)      state_next = S_STORE;
        else if (bus.lc) state_next = S_LDC0;
      end
      // A dr that has already dropped here is treated as a glitch.
      S_STORE: state_next = bus.dr ? S_ZERO : S_EIDLE;
      S_ZERO:  state_next = S_SORT1;
      S_SORT1: state_next = S_SORT2;
      S_SORT2: state_next = S_SORT3;
      S_SORT3: state_next = S_SORT4;
      S_SORT4: state_next = S_MUL1;
      S_MUL1:  state_next = S_ADD1;
      S_ADD1:  state_next = bus.overflow ? S_EIDLE : S_MUL2;
      S_MUL2:  state_next = S_SUB2;
      S_SUB2:  state_next = bus.overflow ? S_EIDLE : S_MUL3;
      S_MUL3:  state_next = S_ADD3;
      S_ADD3:  state_next = bus.overflow ? S_EIDLE : S_MUL4;
      S_MUL4:  state_next = S_SUB4;
      S_SUB4:  state_next = bus.overflow ? S_EIDLE : S_IDLE;
      S_LDC0:  state_next = S_WC0;
      S_LDC1:  state_next = S_WC1;
      S_LDC2:  state_next = S_WC2;
      S_LDC3:  state_next = S_IDLE;
      S_WC0:   if (bus.lc) state_next = S_LDC1;
      S_WC1:   if (bus.lc) state_next = S_LDC2;
      S_WC2:   if (bus.lc) state_next = S_LDC3;
      S_EIDLE: begin
        if (bus.dr)      state_next = S_STORE;
        else if (bus.lc) state_next = S_LDC0;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath command decode: a pure function of the current state.
  always_comb begin
    op_c     = OP_NOP;
    src1_c   = R0;
    src2_c   = R0;
    dest_c   = R0;
    cnt_up_c = 1'b0;
    clear_c  = 1'b0;
    case (state)
      S_STORE: begin
        op_c     = OP_LOAD1;
        dest_c   = R10;
        cnt_up_c = 1'b1;
      end
      S_ZERO:  begin op_c = OP_SUB;  src1_c = R0;  src2_c = R0; dest_c = R0; end
      S_SORT1: begin op_c = OP_COPY; src1_c = R3;  dest_c = R4; end
      S_SORT2: begin op_c = OP_COPY; src1_c = R2;  dest_c = R3; end
      S_SORT3: begin op_c = OP_COPY; src1_c = R1;  dest_c = R2; end
      S_SORT4: begin op_c = OP_COPY; src1_c = R10; dest_c = R1; end
      S_MUL1:  begin op_c = OP_MUL;  src1_c = R1;  src2_c = R5; dest_c = R9; end
      S_ADD1:  begin op_c = OP_ADD;  src1_c = R0;  src2_c = R9; dest_c = R0; end
      S_MUL2:  begin op_c = OP_MUL;  src1_c = R2;  src2_c = R6; dest_c = R9; end
      S_SUB2:  begin op_c = OP_SUB;  src1_c = R0;  src2_c = R9; dest_c = R0; end
      S_MUL3:  begin op_c = OP_MUL;  src1_c = R3;  src2_c = R7; dest_c = R9; end
      S_ADD3:  begin op_c = OP_ADD;  src1_c = R0;  src2_c = R9; dest_c = R0; end
      S_MUL4:  begin op_c = OP_MUL;  src1_c = R4;  src2_c = R8; dest_c = R9; end
      S_SUB4:  begin op_c = OP_SUB;  src1_c = R0;  src2_c = R9; dest_c = R0; end
      S_LDC0: begin
        op_c    = OP_LOAD2;
        dest_c  = R5;
        clear_c = 1'b1;
      end
      S_LDC1:  begin op_c = OP_LOAD2; dest_c = R6; end
      S_LDC2:  begin op_c = OP_LOAD2; dest_c = R7; end
      S_LDC3:  begin op_c = OP_LOAD2; dest_c = R8; end
      default: begin
        op_c = OP_NOP;
      end
    endcase
  end

  assign bus.op      = OP_W'(op_c);
  assign bus.src1    = REG_SEL_W'(src1_c);
  assign bus.src2    = REG_SEL_W'(src2_c);
  assign bus.dest    = REG_SEL_W'(dest_c);
  assign bus.cnt_up  = cnt_up_c;
  assign bus.clear   = clear_c;
  assign bus.modwait = modwait_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_fir_controller.sv
// Scoreboard bench for fir_controller: stimulus pushes the expected
// datapath commands, a negedge monitor pops one per non-NOP cycle.
module tb_fir_controller;

  typedef struct packed {
    logic [2:0] op;
    logic [3:0] s1;
    logic [3:0] s2;
    logic [3:0] d;
    logic       cu;
    logic       cl;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   mon_en = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_pop = 0;
  exp_t q[$];

  fir_controller_if #(.OP_W(3), .REG_SEL_W(4)) bus ();

  fir_controller #(.OP_W(3), .REG_SEL_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic [2:0] op, input logic [3:0] s1, input logic [3:0] s2,
                              input logic [3:0] d, input logic cu, input logic cl);
    exp_t e;
    e.op = op; e.s1 = s1; e.s2 = s2; e.d = d; e.cu = cu; e.cl = cl;
    return e;
  endfunction

  // Hand-written command list for one sample: first n steps of STORE..SUB4.
  task automatic push_sample(input int n);
    exp_t seq[14];
    seq[0]  = mk(3'd2, 4'd0,  4'd0, 4'd10, 1'b1, 1'b0); // STORE LOAD1 ->R10
    seq[1]  = mk(3'd5, 4'd0,  4'd0, 4'd0,  1'b0, 1'b0); // ZERO  R0-R0
    seq[2]  = mk(3'd1, 4'd3,  4'd0, 4'd4,  1'b0, 1'b0); // R3->R4
    seq[3]  = mk(3'd1, 4'd2,  4'd0, 4'd3,  1'b0, 1'b0); // R2->R3
    seq[4]  = mk(3'd1, 4'd1,  4'd0, 4'd2,  1'b0, 1'b0); // R1->R2
    seq[5]  = mk(3'd1, 4'd10, 4'd0, 4'd1,  1'b0, 1'b0); // R10->R1
    seq[6]  = mk(3'd6, 4'd1,  4'd5, 4'd9,  1'b0, 1'b0); // R1*R5
    seq[7]  = mk(3'd4, 4'd0,  4'd9, 4'd0,  1'b0, 1'b0); // R0+R9
    seq[8]  = mk(3'd6, 4'd2,  4'd6, 4'd9,  1'b0, 1'b0); // R2*R6
    seq[9]  = mk(3'd5, 4'd0,  4'd9, 4'd0,  1'b0, 1'b0); // R0-R9
    seq[10] = mk(3'd6, 4'd3,  4'd7, 4'd9,  1'b0, 1'b0); // R3*R7
    seq[11] = mk(3'd4, 4'd0,  4'd9, 4'd0,  1'b0, 1'b0); // R0+R9
    seq[12] = mk(3'd6, 4'd4,  4'd8, 4'd9,  1'b0, 1'b0); // R4*R8
    seq[13] = mk(3'd5, 4'd0,  4'd9, 4'd0,  1'b0, 1'b0); // R0-R9
    for (int i = 0; i < n; i++) q.push_back(seq[i]);
  endtask

  // Four coefficient strobes (0x8000, 0x4000, 0x2000, 0x1000 on the data
  // bus); dr pulses while waiting must be ignored.
  task automatic load_coeffs();
    for (int n = 0; n < 4; n++) begin
      q.push_back(mk(3'd3, 4'd0, 4'd0, 4'(5 + n), 1'b0, (n == 0)));
      bus.lc = 1'b1;
      tick();
      check($sformatf("ldc%0d_modwait", n), bus.modwait, 1);
      check($sformatf("ldc%0d_err", n), bus.err, 0);
      bus.lc = 1'b0;
      tick();
      check($sformatf("after_ldc%0d_modwait", n), bus.modwait, 0);
      if (n < 3) begin
        bus.dr = 1'b1;
        tick();
        bus.dr = 1'b0;
        tick();
        check($sformatf("wc%0d_modwait", n), bus.modwait, 0);
      end
    end
  endtask

  // Monitor: every non-NOP command must match the head of the queue;
  // NOP cycles must carry no selects and no pulses.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.op != 3'd0) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_op: got op=%0d s1=%0d s2=%0d d=%0d, want no command (t=%0t)",
                   bus.op, bus.src1, bus.src2, bus.dest, $time);
        end else begin
          exp_t e;
          exp_t a;
          e = q.pop_front();
          a = mk(bus.op, bus.src1, bus.src2, bus.dest, bus.cnt_up, bus.clear);
          n_pop++;
          if (a !== e) begin
            n_bad++;
            $display("FAIL cmd%0d: got op=%0d s1=%0d s2=%0d d=%0d cu=%0d cl=%0d, want op=%0d s1=%0d s2=%0d d=%0d cu=%0d cl=%0d",
                     n_pop, a.op, a.s1, a.s2, a.d, a.cu, a.cl, e.op, e.s1, e.s2, e.d, e.cu, e.cl);
          end
        end
      end else begin
        check("nop_fields", {bus.src1, bus.src2, bus.dest, bus.cnt_up, bus.clear}, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int busy;
    bus.dr = 1'b0;
    bus.lc = 1'b0;
    bus.overflow = 1'b0;

    // Reset state.
    rst = 1'b1;
    tick();
    tick();
    check("rst_op", bus.op, 0);
    check("rst_modwait", bus.modwait, 0);
    check("rst_err", bus.err, 0);
    check("rst_pulses", {bus.cnt_up, bus.clear}, 0);
    rst = 1'b0;
    mon_en = 1'b1;
    tick();

    // Coefficient load.
    load_coeffs();

    // dr held 3 edges: one sample, 14 busy cycles.
    push_sample(14);
    bus.dr = 1'b1;
    tick();
    busy = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 2) bus.dr = 1'b0;
      if (bus.modwait) busy++;
      tick();
    end
    check("busy_cycles", busy, 14);
    check("seq_err", bus.err, 0);

    // dr glitch: low in STORE -> EIDLE, then a clean sample recovers.
    push_sample(1);
    bus.dr = 1'b1;
    tick();
    bus.dr = 1'b0;
    tick();
    check("glitch_err", bus.err, 1);
    check("glitch_modwait", bus.modwait, 0);
    tick();
    check("eidle_hold_err", bus.err, 1);
    push_sample(14);
    bus.dr = 1'b1;
    tick();
    check("recover_err", bus.err, 0);
    check("recover_modwait", bus.modwait, 1);
    tick();
    bus.dr = 1'b0;
    repeat (13) tick();
    check("recover_idle_modwait", bus.modwait, 0);
    check("recover_idle_err", bus.err, 0);

    // dr and lc together: sample wins, lc ignored for the whole run.
    push_sample(14);
    bus.dr = 1'b1;
    bus.lc = 1'b1;
    tick();
    tick();
    bus.dr = 1'b0;
    repeat (12) tick();
    check("both_sub4_modwait", bus.modwait, 1);
    bus.lc = 1'b0;
    tick();
    check("both_idle_modwait", bus.modwait, 0);
    repeat (3) tick();
    check("both_idle_op", bus.op, 0);

    // Overflow in ADD3 -> EIDLE, no SUB4 or later commands.
    push_sample(12);
    bus.dr = 1'b1;
    tick();
    tick();
    bus.dr = 1'b0;
    repeat (10) tick();
    bus.overflow = 1'b1;
    tick();
    bus.overflow = 1'b0;
    check("ovf_err", bus.err, 1);
    check("ovf_modwait", bus.modwait, 0);
    tick();
    check("ovf_op", bus.op, 0);

    // Coefficient load straight out of EIDLE.
    load_coeffs();

    // Reset held 2 cycles in MUL2.
    push_sample(9);
    bus.dr = 1'b1;
    tick();
    tick();
    bus.dr = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    check("midrst_op", bus.op, 0);
    check("midrst_modwait", bus.modwait, 0);
    check("midrst_err", bus.err, 0);
    tick();
    rst = 1'b0;
    tick();
    check("postrst_modwait", bus.modwait, 0);
    check("postrst_op", bus.op, 0);

    repeat (2) tick();
    check("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
